// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues one fetch at a time to instruction memory and buffers
// returned words in a DEPTH-entry FIFO toward decode. A flush drops queued and in-flight work.
module instruction_fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pcAdvance,
  input  logic        flush,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  input  logic        idStall,
  output logic        idValid,
  output logic [31:0] idInstruction,
  output logic [31:0] idPc,
  output logic [31:0] idPcPlus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   addr_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          req;
  logic          push;
  logic          pop;

  always_comb begin
    req       = (state == IDLE) && !flush && !reset && (count < FULL);
    push      = (state == WAIT) && imemAck && !flush;
    pop       = (count != '0) && !idStall && !flush;
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      // an ack coinciding with flush retires the request, so nothing is left to discard
      WAIT:    if (imemAck) state_nxt = IDLE;
               else if (flush) state_nxt = DISCARD;
      DISCARD: if (imemAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (req) addr_q <= pc;
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= imemRdata;
      pc_mem[tail]    <= addr_q;
    end
  end

  assign imemReq       = req;
  assign pcAdvance     = req;
  assign imemAddr      = (state == IDLE) ? pc : addr_q;
  assign idValid       = (count != '0);
  assign idInstruction = idValid ? instr_mem[head] : NOP;
  assign idPc          = idValid ? pc_mem[head] : 32'h00000000;
  assign idPcPlus4     = idPc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: hand-computed expectations for fetch,
// backpressure, flush, address wrap and reset-while-outstanding scenarios.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pcAdvance;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        idStall;
  logic        idValid;
  logic [31:0] idInstruction;
  logic [31:0] idPc;
  logic [31:0] idPcPlus4;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch_queue #(.DEPTH(2), .NOP(32'h00000000)) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .pcAdvance(pcAdvance),
    .flush(flush),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemAck(imemAck),
    .imemRdata(imemRdata),
    .idStall(idStall),
    .idValid(idValid),
    .idInstruction(idInstruction),
    .idPc(idPc),
    .idPcPlus4(idPcPlus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // step past the next rising edge; inputs are changed afterwards, then settled with #1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // one fetch with single-cycle memory latency; expects a request pending on entry
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_req"}, {31'd0, imemReq}, 32'd1);
    chk({tag, "_addr"}, imemAddr, addr);
    tick();
    imemAck   = 1'b1;
    imemRdata = data;
    #1;
    tick();
    imemAck = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; flush = 1'b0; imemAck = 1'b0;
    imemRdata = 32'h0; idStall = 1'b0;
    tick(); tick();
    #1;
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_adv", {31'd0, pcAdvance}, 32'd0);
    reset = 1'b0;
    #1;

    // basic fetch, one-cycle memory latency
    chk("t1_valid0", {31'd0, idValid}, 32'd0);
    chk("t1_instr0", idInstruction, 32'h00000000);
    chk("t1_pc0", idPc, 32'h00000000);
    chk("t1_pc4_0", idPcPlus4, 32'h00000004);
    chk("t1_adv", {31'd0, pcAdvance}, 32'd1);
    idStall = 1'b1;
    fetch("t1", 32'h0, 32'h20080005);
    chk("t1_valid", {31'd0, idValid}, 32'd1);
    chk("t1_instr", idInstruction, 32'h20080005);
    chk("t1_pc", idPc, 32'h00000000);
    chk("t1_pc4", idPcPlus4, 32'h00000004);

    // backpressure: two entries fill the queue, third fetch held off
    do_reset();
    idStall = 1'b1; pc = 32'h0;
    #1;
    fetch("t2a", 32'h0, 32'h11111111);
    pc = 32'h4;
    #1;
    fetch("t2b", 32'h4, 32'h22222222);
    pc = 32'h8;
    #1;
    chk("t2_full_req", {31'd0, imemReq}, 32'd0);
    chk("t2_full_adv", {31'd0, pcAdvance}, 32'd0);
    tick();
    chk("t2_full_req2", {31'd0, imemReq}, 32'd0);
    chk("t2_head0", idPc, 32'h0);
    idStall = 1'b0;
    #1;
    chk("t2_instr0", idInstruction, 32'h11111111);
    tick();
    idStall = 1'b1;
    #1;
    chk("t2_head1", idPc, 32'h4);
    chk("t2_instr1", idInstruction, 32'h22222222);
    // third fetch lands in the wrapped tail slot
    fetch("t2c", 32'h8, 32'h33333333);
    chk("t2_wrap_head", idPc, 32'h4);
    idStall = 1'b0;
    #1;
    tick();
    chk("t2_wrap_pc", idPc, 32'h8);
    chk("t2_wrap_instr", idInstruction, 32'h33333333);

    // flush while waiting; late ack dropped
    do_reset();
    idStall = 1'b0; pc = 32'h10;
    #1;
    tick();
    flush = 1'b1; pc = 32'h40;
    #1;
    chk("t3_flush_req", {31'd0, imemReq}, 32'd0);
    chk("t3_hold_addr", imemAddr, 32'h10);
    tick();
    flush = 1'b0;
    #1;
    chk("t3_disc_req", {31'd0, imemReq}, 32'd0);
    tick(); tick();
    imemAck = 1'b1; imemRdata = 32'hDEADBEEF;
    #1;
    tick();
    imemAck = 1'b0;
    #1;
    chk("t3_valid", {31'd0, idValid}, 32'd0);
    chk("t3_newreq", {31'd0, imemReq}, 32'd1);
    chk("t3_newaddr", imemAddr, 32'h40);

    // ack coincident with flush: data dropped, back to idle
    tick();
    imemAck = 1'b1; flush = 1'b1; imemRdata = 32'h55555555;
    #1;
    tick();
    imemAck = 1'b0; flush = 1'b0;
    #1;
    chk("t3b_valid", {31'd0, idValid}, 32'd0);
    chk("t3b_req", {31'd0, imemReq}, 32'd1);

    // flush with a full, stalled queue
    do_reset();
    idStall = 1'b1; pc = 32'h100;
    #1;
    fetch("t4a", 32'h100, 32'hAAAA0001);
    pc = 32'h104;
    #1;
    fetch("t4b", 32'h104, 32'hAAAA0002);
    chk("t4_full_valid", {31'd0, idValid}, 32'd1);
    chk("t4_full_req", {31'd0, imemReq}, 32'd0);
    flush = 1'b1; pc = 32'h200;
    #1;
    tick();
    flush = 1'b0;
    #1;
    chk("t4_valid", {31'd0, idValid}, 32'd0);
    chk("t4_instr", idInstruction, 32'h0);
    chk("t4_req", {31'd0, imemReq}, 32'd1);
    chk("t4_addr", imemAddr, 32'h200);

    // address wrap on idPcPlus4
    do_reset();
    idStall = 1'b1; pc = 32'hFFFFFFFC;
    #1;
    fetch("t5", 32'hFFFFFFFC, 32'h12345678);
    chk("t5_pc", idPc, 32'hFFFFFFFC);
    chk("t5_pc4", idPcPlus4, 32'h00000000);
    chk("t5_instr", idInstruction, 32'h12345678);

    // reset while a request is outstanding; stale ack ignored
    do_reset();
    idStall = 1'b0; pc = 32'h300;
    #1;
    tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, imemReq}, 32'd0);
    chk("t6_rst_adv", {31'd0, pcAdvance}, 32'd0);
    tick();
    reset = 1'b0; pc = 32'h400; imemAck = 1'b1; imemRdata = 32'h0BAD0BAD;
    #1;
    chk("t6_after_valid", {31'd0, idValid}, 32'd0);
    chk("t6_after_pc4", idPcPlus4, 32'h4);
    chk("t6_fresh_req", {31'd0, imemReq}, 32'd1);
    chk("t6_fresh_addr", imemAddr, 32'h400);
    tick();
    imemAck = 1'b0;
    #1;
    chk("t6_stale_valid", {31'd0, idValid}, 32'd0);
    chk("t6_wait_req", {31'd0, imemReq}, 32'd0);
    chk("t6_wait_addr", imemAddr, 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 2, queue entries (power of two, >=2).
REQ-002 SHALL have parameter: NOP, 32'h00000000, instruction driven when queue empty.
REQ-003 SHALL have port: clk  input  1  clock, rising-edge.
REQ-004 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: pc  input  32  current program counter value.
REQ-006 SHALL have port: pcAdvance  output  1  high when program counter loads next value this edge; program counter hazard = !pcAdvance.
REQ-007 SHALL have port: flush  input  1  taken branch/jump; discard all fetched and in-flight work.
REQ-008 SHALL have port: imemReq  output  1  single-cycle fetch request pulse.
REQ-009 SHALL have port: imemAddr  output  32  fetch address.
REQ-010 SHALL have port: imemAck  input  1  single-cycle response strobe, latency >=1 cycle after imemReq.
REQ-011 SHALL have port: imemRdata  input  32  instruction word, valid with imemAck.
REQ-012 SHALL have port: idStall  input  1  decode cannot accept head entry.
REQ-013 SHALL have port: idValid  output  1  head entry valid.
REQ-014 SHALL have port: idInstruction  output  32  head instruction, NOP when empty.
REQ-015 SHALL have port: idPc  output  32  head entry fetch address, 0 when empty.
REQ-016 SHALL have port: idPcPlus4  output  32  idPc + 4 modulo 2^32.

Function
REQ-017 SHALL implement FSM states IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (flushed request outstanding).
REQ-018 SHALL assert imemReq and pcAdvance combinationally iff state==IDLE, flush==0, reset==0, count<DEPTH; then transition to WAIT.
REQ-019 SHALL drive imemAddr = pc in IDLE; SHALL latch pc on request and hold imemAddr stable in WAIT and DISCARD.
REQ-020 SHALL allow at most one outstanding request; no imemReq in WAIT or DISCARD.
REQ-021 SHALL, on imemAck in WAIT with flush==0, push {imemRdata, imemAddr} at tail and go to IDLE; entry visible on idValid the following cycle.
REQ-022 SHALL, on flush in WAIT, go to DISCARD; imemAck in DISCARD (with or without flush) dropped, go to IDLE.
REQ-023 SHALL, on imemAck in WAIT coincident with flush, drop the data and go to IDLE.
REQ-024 SHALL ignore imemAck in IDLE.
REQ-025 SHALL pop head at clock edge when idValid==1 and idStall==0 and flush==0.
REQ-026 SHALL, on flush, set count and pointers to 0 at that edge regardless of idStall; idValid==0 next cycle.
REQ-027 SHALL support simultaneous push and pop (count unchanged, order preserved); push when full cannot occur by REQ-018.
REQ-028 SHALL deliver entries to decode in fetch order; pointers wrap modulo DEPTH.
REQ-029 SHALL drive idValid = (count!=0); idInstruction/idPc from head when valid, else NOP/0.
REQ-030 SHALL compute idPcPlus4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).

Reset
REQ-031 SHALL, while reset high, force state IDLE, count 0, pointers 0, latched address 0, imemReq 0, pcAdvance 0.
REQ-032 SHALL, after reset (including mid-WAIT), ignore any subsequent stale imemAck until a new request is issued.
REQ-033 SHALL output idValid 0, idInstruction NOP, idPc 0, idPcPlus4 4 the cycle after reset.

Verification
REQ-034 SHALL test: reset, pc=0x00000000, imemAck 1 cycle after imemReq with 0x20080005 -> pcAdvance pulse with imemReq; next cycle idValid=1, idInstruction=0x20080005, idPc=0, idPcPlus4=4.
REQ-035 SHALL test: idStall held, pc 0x0,0x4,0x8 -> two entries queued, no third imemReq, pcAdvance stays 0; release idStall -> 0x0 then 0x4 delivered in order, third fetch issued.
REQ-036 SHALL test: flush in WAIT, imemAck 3 cycles later with 0xDEADBEEF -> data dropped, idValid stays 0, next imemReq uses new pc 0x40.
REQ-037 SHALL test: queue full with idStall=1, flush -> idValid=0 next cycle, count 0, new fetch issued.
REQ-038 SHALL test: pc=0xFFFFFFFC fetched -> idPc=0xFFFFFFFC, idPcPlus4=0x00000000.
REQ-039 SHALL test: reset asserted in WAIT, imemAck arrives after reset release -> ignored, idValid=0, fresh imemReq to current pc.
